// File: rtl/sram_arb_pkg.sv
// sram_arb_pkg: shared state type, gap length and index-width helper for the SRAM arbiter.
package sram_arb_pkg;
  typedef enum logic [1:0] {ARB_IDLE, ARB_BUSY, ARB_GAP} arb_state_t;
  localparam int ARB_GAP_CYCLES = 1;
  function automatic int clog2(input int n);
    int r;
    r = 1;
    while ((1 << r) < n) r++;
    return r;
  endfunction
endpackage

// File: rtl/sram_arb_rr_pick.sv
// sram_arb_rr_pick: combinational winner pick, round-robin by default, lowest index with SRAM_ARB_FIXED_PRIO_EN.
module sram_arb_rr_pick
  import sram_arb_pkg::*;
#(
  parameter int N_REQ = 2,
  localparam int IDX_W = clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] last_grant,
  output logic [N_REQ-1:0] grant,
  output logic [IDX_W-1:0] idx
);
`ifdef SRAM_ARB_FIXED_PRIO_EN
  logic unused_last_grant;
  assign unused_last_grant = ^last_grant;
  always_comb begin
    grant = '0;
    idx = '0;
    for (int i = N_REQ - 1; i >= 0; i--)
      if (req[IDX_W'(i)]) begin
        grant = N_REQ'(1) << i;
        idx = IDX_W'(i);
      end
  end
`else
  // Scan from farthest to nearest offset so the nearest requester after last_grant wins.
  always_comb begin
    logic [IDX_W-1:0] j;
    grant = '0;
    idx = '0;
    j = '0;
    for (int i = N_REQ; i >= 1; i--) begin
      j = IDX_W'((int'(last_grant) + i) % N_REQ);
      if (req[j]) begin
        grant = N_REQ'(1) << j;
        idx = j;
      end
    end
  end
`endif
endmodule

// File: rtl/sram_arbiter.sv
// sram_arbiter: shares one SRAM controller port among N_REQ requesters with registered command and ack.
// Build option SRAM_ARB_FIXED_PRIO_EN selects fixed lowest-index priority instead of round-robin.
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int N_REQ  = 2,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ-1:0]        req_we,
  input  logic [N_REQ*ADDR_W-1:0] req_addr,
  input  logic [N_REQ*DATA_W-1:0] req_wdata,
  output logic [N_REQ-1:0]        ack,
  output logic [DATA_W-1:0]       rdata,
  output logic                    busy,
  output logic                    mem_write_en,
  output logic                    mem_read_en,
  output logic [ADDR_W-1:0]       mem_addr,
  output logic [DATA_W-1:0]       mem_wdata,
  input  logic [DATA_W-1:0]       mem_rdata,
  input  logic                    mem_ready
);
  localparam int IDX_W = clog2(N_REQ);
  arb_state_t       state;
  logic [IDX_W-1:0] last_grant;
  logic [IDX_W-1:0] pick_idx;
  logic [N_REQ-1:0] pick_grant;
  logic [N_REQ-1:0] win_oh;
  logic             first;
  logic             is_we;
  logic [3:0]       gap_cnt;
  sram_arb_rr_pick #(.N_REQ(N_REQ)) u_pick (
    .req(req),
    .last_grant(last_grant),
    .grant(pick_grant),
    .idx(pick_idx)
  );
  // The controller reports ready while idle, so the first BUSY cycle must not trust it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ARB_IDLE;
      ack <= '0;
      rdata <= '0;
      busy <= 1'b0;
      mem_write_en <= 1'b0;
      mem_read_en <= 1'b0;
      mem_addr <= '0;
      mem_wdata <= '0;
      last_grant <= IDX_W'(N_REQ - 1);
      win_oh <= '0;
      first <= 1'b0;
      is_we <= 1'b0;
      gap_cnt <= '0;
    end else begin
      ack <= '0;
      case (state)
        ARB_IDLE:
          if (|req) begin
            state <= ARB_BUSY;
            busy <= 1'b1;
            win_oh <= pick_grant;
            last_grant <= pick_idx;
            mem_addr <= req_addr[pick_idx*ADDR_W +: ADDR_W];
            mem_wdata <= req_wdata[pick_idx*DATA_W +: DATA_W];
            is_we <= req_we[pick_idx];
            mem_write_en <= req_we[pick_idx];
            mem_read_en <= ~req_we[pick_idx];
            first <= 1'b1;
          end
        ARB_BUSY: begin
          first <= 1'b0;
          if (!first && mem_ready) begin
            ack <= win_oh;
            rdata <= is_we ? rdata : mem_rdata;
            mem_write_en <= 1'b0;
            mem_read_en <= 1'b0;
            gap_cnt <= '0;
            state <= ARB_GAP;
          end
        end
        ARB_GAP:
          if (gap_cnt == 4'(ARB_GAP_CYCLES - 1)) begin
            state <= ARB_IDLE;
            busy <= 1'b0;
          end else gap_cnt <= gap_cnt + 4'd1;
        default: state <= ARB_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: directed self-checking bench with a small SRAM controller model (ready on 8th enabled cycle).
module tb_sram_arbiter;
`ifdef SRAM_ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  req = '0;
  logic [1:0]  req_we = '0;
  logic [63:0] req_addr = '0;
  logic [63:0] req_wdata = '0;
  logic [1:0]  ack;
  logic [31:0] rdata;
  logic        busy;
  logic        mem_write_en;
  logic        mem_read_en;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic [31:0] sram [0:1023];
  int          cnt = 0;
  int          tests = 0;
  int          fails = 0;
  logic [31:0] cap_addr, cap_wdata;
  logic        cap_we;
  int          n, en_hi;
  logic [1:0]  a;
  always #5 clk = ~clk;
  sram_arbiter #(.N_REQ(2), .ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst), .req(req), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .ack(ack), .rdata(rdata), .busy(busy),
    .mem_write_en(mem_write_en), .mem_read_en(mem_read_en), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );
  // Controller model: counts enabled cycles, ready once 7 edges have passed with enable high.
  always @(posedge clk) begin
    if (!(mem_read_en | mem_write_en)) cnt <= 0;
    else if (cnt < 7) cnt <= cnt + 1;
    if (mem_write_en && mem_ready) sram[mem_addr[11:2]] <= mem_wdata;
  end
  assign mem_ready = !(mem_read_en | mem_write_en) || cnt == 7;
  assign mem_rdata = sram[mem_addr[11:2]];
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic wait_ack(output int nn, output int ee, output logic [1:0] aa);
    nn = 0;
    ee = 0;
    aa = '0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      nn++;
      if (ack != 2'b00) begin
        aa = ack;
        break;
      end
      if (mem_read_en | mem_write_en) begin
        ee++;
        if (ee == 1) begin
          cap_addr = mem_addr;
          cap_wdata = mem_wdata;
          cap_we = mem_write_en;
        end
      end
    end
  endtask
  task automatic gap_chk(input string tag);
    chk({tag, ".gap_en"}, {63'd0, mem_read_en | mem_write_en}, 64'd0);
    chk({tag, ".gap_busy"}, {63'd0, busy}, 64'd1);
    @(negedge clk);
    chk({tag, ".ack_once"}, {62'd0, ack}, 64'd0);
    chk({tag, ".idle"}, {62'd0, busy, mem_read_en | mem_write_en}, 64'd0);
  endtask
  initial begin
    for (int i = 0; i < 1024; i++) sram[i] = 32'h5A00_0000 | i;
    repeat (2) @(negedge clk);
    chk("rst.ack", {62'd0, ack}, 64'd0);
    chk("rst.rdata", {32'd0, rdata}, 64'd0);
    chk("rst.en", {62'd0, mem_read_en, mem_write_en}, 64'd0);
    chk("rst.addr", {32'd0, mem_addr}, 64'd0);
    chk("rst.wdata", {32'd0, mem_wdata}, 64'd0);
    chk("rst.busy", {63'd0, busy}, 64'd0);
    rst = 1'b0;
    @(negedge clk);
    req_addr[31:0] = 32'h400;
    req = 2'b01;
    wait_ack(n, en_hi, a);
    req = 2'b00;
    chk("rd.ack", {62'd0, a}, 64'd1);
    chk("rd.latency", 64'(n - 1), 64'd8);
    chk("rd.en_cycles", 64'(en_hi), 64'd8);
    chk("rd.addr", {32'd0, cap_addr}, 64'h400);
    chk("rd.is_read", {63'd0, cap_we}, 64'd0);
    chk("rd.rdata", {32'd0, rdata}, 64'h5A00_0100);
    gap_chk("rd");
    req_we[1] = 1'b1;
    req_addr[63:32] = 32'h404;
    req_wdata[63:32] = 32'hDEAD_BEEF;
    req = 2'b10;
    wait_ack(n, en_hi, a);
    req = 2'b00;
    chk("wr.ack", {62'd0, a}, 64'd2);
    chk("wr.en_cycles", 64'(en_hi), 64'd8);
    chk("wr.is_write", {63'd0, cap_we}, 64'd1);
    chk("wr.addr", {32'd0, cap_addr}, 64'h404);
    chk("wr.wdata", {32'd0, cap_wdata}, 64'hDEAD_BEEF);
    chk("wr.sram", {32'd0, sram[257]}, 64'hDEAD_BEEF);
    chk("wr.rdata_kept", {32'd0, rdata}, 64'h5A00_0100);
    gap_chk("wr");
    req_we[1] = 1'b0;
    req = 2'b10;
    wait_ack(n, en_hi, a);
    req = 2'b00;
    chk("rb.ack", {62'd0, a}, 64'd2);
    chk("rb.rdata", {32'd0, rdata}, 64'hDEAD_BEEF);
    gap_chk("rb");
    req = 2'b11;
    for (int k = 0; k < 4; k++) begin
      wait_ack(n, en_hi, a);
      if (k == 3) req = 2'b00;
      chk($sformatf("ct%0d.ack", k), {62'd0, a}, (FIXED || k % 2 == 0) ? 64'd1 : 64'd2);
      chk($sformatf("ct%0d.rdata", k), {32'd0, rdata},
          (FIXED || k % 2 == 0) ? 64'h5A00_0100 : 64'hDEAD_BEEF);
      chk($sformatf("ct%0d.spacing", k), 64'(n + (k == 0 ? 0 : 1)), k == 0 ? 64'd9 : 64'd10);
      gap_chk($sformatf("ct%0d", k));
    end
    req = 2'b01;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mid_rst.en", {62'd0, mem_read_en, mem_write_en}, 64'd0);
    chk("mid_rst.ack", {62'd0, ack}, 64'd0);
    chk("mid_rst.busy", {63'd0, busy}, 64'd0);
    chk("mid_rst.rdata", {32'd0, rdata}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    wait_ack(n, en_hi, a);
    req = 2'b00;
    chk("post_rst.ack", {62'd0, a}, 64'd1);
    chk("post_rst.latency", 64'(n - 1), 64'd8);
    chk("post_rst.en_cycles", 64'(en_hi), 64'd8);
    chk("post_rst.rdata", {32'd0, rdata}, 64'h5A00_0100);
    gap_chk("post_rst");
    req = 2'b01;
    repeat (2) @(negedge clk);
    req = 2'b00;
    wait_ack(n, en_hi, a);
    chk("drop.ack", {62'd0, a}, 64'd1);
    chk("drop.remaining", 64'(n), 64'd7);
    gap_chk("drop");
    en_hi = 0;
    repeat (15) begin
      @(negedge clk);
      if (ack != 2'b00 || busy) en_hi++;
    end
    chk("drop.no_extra", 64'(en_hi), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
